// File: rtl/seven_seg_scan.sv
// seven_seg_scan: eight-digit time-multiplexed driver for a common-anode
// seven-segment display. A full frame of digit values and decimal points is
// captured at a time, so the scanned image never tears. Optional leading-zero
// blanking applies to that captured frame. All display lines are active-low.
module seven_seg_scan #(
    parameter int DIV = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] SEVENSEGHEX,
    input  logic [7:0]  DP_MASK,
    input  logic        LZ_BLANK,
    output logic [7:0]  AN,
    output logic [7:0]  SEG
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_active;
    logic [31:0]   r_shVal;
    logic [7:0]    r_shDp;
    logic [7:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_tick;
    logic          w_blank;
    logic [3:0]    w_nibble;
    logic [6:0]    w_code;

    assign w_tick   = (r_cnt == CNT_MAX);
    assign w_nibble = r_shVal[{r_idx, 2'b00} +: 4];
    assign w_blank  = LZ_BLANK && (r_idx != 3'd0) &&
                      ((r_shVal >> {r_idx, 2'b00}) == 32'd0);

    // Prescaler, digit index and frame shadow; reset leaves the index on digit 7
    // with the prescaler at its last count, so the first clock after reset
    // is a frame load.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt    <= CNT_MAX;
            r_idx    <= 3'd7;
            r_active <= 1'b0;
            r_shVal  <= 32'd0;
            r_shDp   <= 8'd0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
                r_shVal  <= SEVENSEGHEX;
                r_shDp   <= DP_MASK;
                r_active <= 1'b1;
            end
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
    always_comb begin
        w_code = 7'h7F;
        case (w_nibble)
            4'h0: w_code = 7'h40;
            4'h1: w_code = 7'h79;
            4'h2: w_code = 7'h24;
            4'h3: w_code = 7'h30;
            4'h4: w_code = 7'h19;
            4'h5: w_code = 7'h12;
            4'h6: w_code = 7'h02;
            4'h7: w_code = 7'h78;
            4'h8: w_code = 7'h00;
            4'h9: w_code = 7'h10;
            4'hA: w_code = 7'h08;
            4'hB: w_code = 7'h03;
            4'hC: w_code = 7'h46;
            4'hD: w_code = 7'h21;
            4'hE: w_code = 7'h06;
            4'hF: w_code = 7'h0E;
            default: w_code = 7'h7F;
        endcase
    end

    // Registered pin drivers: dark until the first frame is latched, dark for
    // blanked leading zeros, otherwise the current digit with its decimal point.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else if (!r_active || w_blank) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(8'b1 << r_idx);
            r_seg <= {~r_shDp[r_idx], w_code};
        end
    end

    assign AN  = r_an;
    assign SEG = r_seg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: drives two scanners (DIV=4 and DIV=1) from shared inputs
// and compares both against a frame-level model of what each display shows.
module tb_seven_seg_scan;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] hexIn;
    logic [7:0]  dpIn;
    logic        lzIn;
    logic [7:0]  an4, seg4, an1, seg1;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 for the DIV=4 instance and 1 for DIV=1.
    int          edgeNum[2];
    logic [31:0] frameVal[2];
    logic [7:0]  frameDp[2];
    logic [7:0]  expAn[2];
    logic [7:0]  expSeg[2];

    always #5 CLK = ~CLK;

    seven_seg_scan #(.DIV(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .SEVENSEGHEX(hexIn), .DP_MASK(dpIn),
        .LZ_BLANK(lzIn), .AN(an4), .SEG(seg4)
    );

    seven_seg_scan #(.DIV(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .SEVENSEGHEX(hexIn), .DP_MASK(dpIn),
        .LZ_BLANK(lzIn), .AN(an1), .SEG(seg1)
    );

    function automatic int divOf(input int m);
        return (m == 0) ? 4 : 1;
    endfunction

    // Active-low {g..a} patterns for hex digits 0..F.
    function automatic logic [6:0] segCode(input logic [3:0] n);
        logic [6:0] table7 [16];
        table7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return table7[n];
    endfunction

    // Position of the most significant nonzero digit (0 when the value is 0).
    function automatic int topDigit(input logic [31:0] v);
        int t = 0;
        for (int i = 0; i < 8; i++) begin
            if (((v >> (4 * i)) & 32'hF) != 0) t = i;
        end
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] v, input logic [7:0] dp,
                                 input logic lz);
        hexIn = v;
        dpIn  = dp;
        lzIn  = lz;
    endtask

    // One clock: advance the model on the edge, then compare both instances.
    task automatic stepCycle();
        @(posedge CLK);
        for (int m = 0; m < 2; m++) begin
            int div = divOf(m);
            if (RESET) begin
                edgeNum[m]  = 0;
                frameVal[m] = 32'd0;
                frameDp[m]  = 8'd0;
                expAn[m]    = 8'hFF;
                expSeg[m]   = 8'hFF;
            end else begin
                int k;
                edgeNum[m]++;
                k = edgeNum[m];
                if (k < 2) begin
                    expAn[m]  = 8'hFF;
                    expSeg[m] = 8'hFF;
                end else begin
                    int d = ((k - 2) / div) % 8;
                    if (lzIn && d > topDigit(frameVal[m])) begin
                        expAn[m]  = 8'hFF;
                        expSeg[m] = 8'hFF;
                    end else begin
                        expAn[m]  = ~(8'd1 << d);
                        expSeg[m] = {~frameDp[m][d],
                                     segCode(4'((frameVal[m] >> (4 * d)) & 32'hF))};
                    end
                end
                if ((k - 1) % (8 * div) == 0) begin
                    frameVal[m] = hexIn;
                    frameDp[m]  = dpIn;
                end
            end
        end
        #1;
        checkOutput("an_div4", an4, expAn[0]);
        checkOutput("seg_div4", seg4, expSeg[0]);
        checkOutput("an_div1", an1, expAn[1]);
        checkOutput("seg_div1", seg1, expSeg[1]);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    // Directed scenarios from the display's behaviour, then randomized traffic.
    initial begin
        RESET = 1'b1;
        applyStimulus($urandom, 8'($urandom), 1'b0);
        runCycles(3);
        checkOutput("reset_an", an4, 8'hFF);
        checkOutput("reset_seg", seg4, 8'hFF);

        // Plain scan of 12345678, two full frames.
        applyStimulus(32'h12345678, 8'h00, 1'b0);
        RESET = 1'b0;
        runCycles(2);
        checkOutput("e2_an", an4, 8'hFE);
        checkOutput("e2_seg", seg4, 8'h80);
        checkOutput("e2_an_div1", an1, 8'hFE);
        runCycles(64);

        // Leading-zero blanking, then an all-zero value.
        applyStimulus(32'h000000A0, 8'h00, 1'b1);
        runCycles(70);
        applyStimulus(32'h00000000, 8'h00, 1'b1);
        runCycles(70);

        // Decimal point on digit 2 only.
        applyStimulus(32'h00000000, 8'h04, 1'b0);
        runCycles(70);

        // Mid-frame value change must wait for the next frame load.
        applyStimulus(32'h11111111, 8'h00, 1'b0);
        runCycles(40);
        applyStimulus(32'h22222222, 8'h00, 1'b0);
        runCycles(70);

        // One-cycle reset inside a frame, then restart.
        runCycles(7);
        RESET = 1'b1;
        stepCycle();
        checkOutput("midreset_an", an4, 8'hFF);
        RESET = 1'b0;
        runCycles(2);
        checkOutput("restart_an", an4, 8'hFE);
        runCycles(40);

        // Randomized values, masks, blanking and occasional resets.
        for (int it = 0; it < 30; it++) begin
            applyStimulus($urandom >> (4 * $urandom_range(0, 8)),
                          8'($urandom), 1'($urandom_range(0, 1)));
            RESET = ($urandom_range(0, 9) == 0);
            stepCycle();
            RESET = 1'b0;
            runCycles($urandom_range(1, 40));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
